// File: rtl/execute_pkg.sv
// Shared definitions for the RV32I execute stage.
//   XLEN         datapath width (only 32 is supported)
//   ALU_*        4-bit ALU operation codes driven by decode
//   BR_*         2-bit conditional branch condition selects
package execute_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SLL   = 4'd2;
  localparam logic [3:0] ALU_SLT   = 4'd3;
  localparam logic [3:0] ALU_SLTU  = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_OR    = 4'd8;
  localparam logic [3:0] ALU_AND   = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  localparam logic [1:0] BR_EQ = 2'b00;
  localparam logic [1:0] BR_NE = 2'b01;
  localparam logic [1:0] BR_LT = 2'b10;
  localparam logic [1:0] BR_GE = 2'b11;

endpackage

// File: rtl/alu_core.sv
// Purely combinational 32-bit integer ALU.
//   i_a      operand A
//   i_b      operand B (shifts use only i_b[4:0])
//   i_sel    operation code (ALU_* from execute_pkg); 11-15 give 0
//   o_result result, modulo 2^XLEN
module alu_core
  import execute_pkg::*;
(
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  input  logic [3:0]      i_sel,
  output logic [XLEN-1:0] o_result
);

  logic [4:0] w_shamt;
  logic       w_lt_s;
  logic       w_lt_u;

  assign w_shamt = i_b[4:0];
  assign w_lt_s  = $signed(i_a) < $signed(i_b);
  assign w_lt_u  = i_a < i_b;

  always_comb begin
    o_result = '0;
    case (i_sel)
      ALU_ADD:   o_result = i_a + i_b;
      ALU_SUB:   o_result = i_a - i_b;
      ALU_SLL:   o_result = i_a << w_shamt;
      ALU_SLT:   o_result = {{(XLEN-1){1'b0}}, w_lt_s};
      ALU_SLTU:  o_result = {{(XLEN-1){1'b0}}, w_lt_u};
      ALU_XOR:   o_result = i_a ^ i_b;
      ALU_SRL:   o_result = i_a >> w_shamt;
      ALU_SRA:   o_result = $unsigned($signed(i_a) >>> w_shamt);
      ALU_OR:    o_result = i_a | i_b;
      ALU_AND:   o_result = i_a & i_b;
      ALU_PASSB: o_result = i_b;
      default:   o_result = '0;
    endcase
  end

endmodule

// File: rtl/execute_unit.sv
// RV32I execute stage: ALU, branch comparator, branch-taken decision and
// the E->M pipeline register.
//   clock, reset     rising-edge clock, async active-high reset
//   advance          1 = pipeline register loads, 0 = hold (stall)
//   in_a, in_b       ALU operands; alu_sel selects the operation
//   cmp_a, cmp_b     branch comparator operands; unsign selects BLTU/BGEU
//   brn_enable       instruction is a conditional branch
//   brn_signal       condition select (BR_EQ/BR_NE/BR_LT/BR_GE)
//   alu_out, br_eq, br_lt, br_tk   combinational results (same-cycle redirect)
//   alu_out_q, br_tk_q             registered copies for memory/writeback
module execute_unit #(
  parameter int unsigned XLEN = 32  // only 32 is supported
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            advance,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  input  logic [3:0]      alu_sel,
  input  logic [XLEN-1:0] cmp_a,
  input  logic [XLEN-1:0] cmp_b,
  input  logic            unsign,
  input  logic            brn_enable,
  input  logic [1:0]      brn_signal,
  output logic [XLEN-1:0] alu_out,
  output logic            br_eq,
  output logic            br_lt,
  output logic            br_tk,
  output logic [XLEN-1:0] alu_out_q,
  output logic            br_tk_q
);

  import execute_pkg::*;

  logic [XLEN-1:0] r_alu_out;
  logic            r_br_tk;

  alu_core u_alu_core (
    .i_a      (in_a),
    .i_b      (in_b),
    .i_sel    (alu_sel),
    .o_result (alu_out)
  );

  assign br_eq = (cmp_a == cmp_b);
  assign br_lt = unsign ? (cmp_a < cmp_b) : ($signed(cmp_a) < $signed(cmp_b));

  always_comb begin
    br_tk = 1'b0;
    if (brn_enable) begin
      case (brn_signal)
        BR_EQ:   br_tk = br_eq;
        BR_NE:   br_tk = ~br_eq;
        BR_LT:   br_tk = br_lt;
        BR_GE:   br_tk = ~br_lt;
        default: br_tk = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_alu_out <= '0;
      r_br_tk   <= 1'b0;
    end else if (advance) begin
      r_alu_out <= alu_out;
      r_br_tk   <= br_tk;
    end
  end

  assign alu_out_q = r_alu_out;
  assign br_tk_q   = r_br_tk;

endmodule

// File: tb/tb_execute_unit.sv
module tb_execute_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        advance;
  logic [31:0] in_a, in_b, cmp_a, cmp_b;
  logic [3:0]  alu_sel;
  logic        unsign, brn_enable;
  logic [1:0]  brn_signal;
  logic [31:0] alu_out, alu_out_q;
  logic        br_eq, br_lt, br_tk, br_tk_q;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  execute_unit #(.XLEN(32)) dut (
    .clock      (clock),
    .reset      (reset),
    .advance    (advance),
    .in_a       (in_a),
    .in_b       (in_b),
    .alu_sel    (alu_sel),
    .cmp_a      (cmp_a),
    .cmp_b      (cmp_b),
    .unsign     (unsign),
    .brn_enable (brn_enable),
    .brn_signal (brn_signal),
    .alu_out    (alu_out),
    .br_eq      (br_eq),
    .br_lt      (br_lt),
    .br_tk      (br_tk),
    .alu_out_q  (alu_out_q),
    .br_tk_q    (br_tk_q)
  );

  task automatic test_reset();
    reset = 1'b1; advance = 1'b1;
    in_a = 32'h1234; in_b = 32'h1; alu_sel = 4'd0;
    cmp_a = 0; cmp_b = 0; unsign = 0; brn_enable = 1; brn_signal = 2'b00;
    @(posedge clock); #1;
    checks++;
    if (alu_out_q !== 32'h0) begin
      failures++; $display("FAIL reset_alu_q got=%h exp=%h", alu_out_q, 32'h0);
    end
    checks++;
    if (br_tk_q !== 1'b0) begin
      failures++; $display("FAIL reset_br_tk_q got=%b exp=0", br_tk_q);
    end
    @(negedge clock);
    reset = 1'b0; advance = 1'b0; brn_enable = 1'b0; in_a = 0; in_b = 0;
    #1;
    checks++;
    if (alu_out !== 32'h0) begin
      failures++; $display("FAIL bubble_zero got=%h exp=%h", alu_out, 32'h0);
    end
  endtask

  task automatic test_add_sub();
    in_a = 32'hFFFF_FFFF; in_b = 32'h1; alu_sel = 4'd0; #1;
    checks++;
    if (alu_out !== 32'h0) begin
      failures++; $display("FAIL add_wrap got=%h exp=%h", alu_out, 32'h0);
    end
    in_a = 32'h0; in_b = 32'h1; alu_sel = 4'd1; #1;
    checks++;
    if (alu_out !== 32'hFFFF_FFFF) begin
      failures++; $display("FAIL sub_wrap got=%h exp=%h", alu_out, 32'hFFFF_FFFF);
    end
    advance = 1'b1;
    @(posedge clock); #1;
    advance = 1'b0;
    checks++;
    if (alu_out_q !== 32'hFFFF_FFFF) begin
      failures++; $display("FAIL sub_registered got=%h exp=%h", alu_out_q, 32'hFFFF_FFFF);
    end
    in_a = 32'h0000_0003; in_b = 32'h0000_0005; alu_sel = 4'd5; #1;
    checks++;
    if (alu_out !== 32'h6) begin
      failures++; $display("FAIL xor got=%h exp=%h", alu_out, 32'h6);
    end
    alu_sel = 4'd8; #1;
    checks++;
    if (alu_out !== 32'h7) begin
      failures++; $display("FAIL or got=%h exp=%h", alu_out, 32'h7);
    end
    alu_sel = 4'd9; #1;
    checks++;
    if (alu_out !== 32'h1) begin
      failures++; $display("FAIL and got=%h exp=%h", alu_out, 32'h1);
    end
  endtask

  task automatic test_shifts();
    logic [31:0] exp [3] = '{32'h0000_0000, 32'h4000_0000, 32'hC000_0000};
    logic [3:0]  sel [3] = '{4'd2, 4'd6, 4'd7};
    in_a = 32'h8000_0000; in_b = 32'h0000_0021;
    for (int i = 0; i < 3; i++) begin
      alu_sel = sel[i]; #1;
      checks++;
      if (alu_out !== exp[i]) begin
        failures++; $display("FAIL shift_sel%0d got=%h exp=%h", sel[i], alu_out, exp[i]);
      end
    end
    in_a = 32'h8765_4321; in_b = 32'hFFFF_FFE0; alu_sel = 4'd7; #1;
    checks++;
    if (alu_out !== 32'h8765_4321) begin
      failures++; $display("FAIL sra_by_zero got=%h exp=%h", alu_out, 32'h8765_4321);
    end
  endtask

  task automatic test_slt();
    in_a = 32'h8000_0000; in_b = 32'h1; alu_sel = 4'd3; #1;
    checks++;
    if (alu_out !== 32'h1) begin
      failures++; $display("FAIL slt got=%h exp=%h", alu_out, 32'h1);
    end
    alu_sel = 4'd4; #1;
    checks++;
    if (alu_out !== 32'h0) begin
      failures++; $display("FAIL sltu got=%h exp=%h", alu_out, 32'h0);
    end
    in_b = 32'h1234_5000; alu_sel = 4'd10; #1;
    checks++;
    if (alu_out !== 32'h1234_5000) begin
      failures++; $display("FAIL passb got=%h exp=%h", alu_out, 32'h1234_5000);
    end
    alu_sel = 4'd13; #1;
    checks++;
    if (alu_out !== 32'h0) begin
      failures++; $display("FAIL reserved13 got=%h exp=%h", alu_out, 32'h0);
    end
  endtask

  task automatic test_branch();
    cmp_a = 32'hFFFF_FFFF; cmp_b = 32'h1; unsign = 1'b0;
    brn_enable = 1'b1; brn_signal = 2'b10; #1;
    checks++;
    if (br_lt !== 1'b1) begin
      failures++; $display("FAIL blt_lt got=%b exp=1", br_lt);
    end
    checks++;
    if (br_eq !== 1'b0) begin
      failures++; $display("FAIL blt_eq got=%b exp=0", br_eq);
    end
    checks++;
    if (br_tk !== 1'b1) begin
      failures++; $display("FAIL blt_tk got=%b exp=1", br_tk);
    end
    unsign = 1'b1; #1;
    checks++;
    if (br_lt !== 1'b0) begin
      failures++; $display("FAIL bltu_lt got=%b exp=0", br_lt);
    end
    checks++;
    if (br_tk !== 1'b0) begin
      failures++; $display("FAIL bltu_tk got=%b exp=0", br_tk);
    end
    cmp_a = 32'h5; cmp_b = 32'h5; unsign = 1'b0; brn_signal = 2'b11; #1;
    checks++;
    if (br_tk !== 1'b1) begin
      failures++; $display("FAIL bge_equal got=%b exp=1", br_tk);
    end
    brn_signal = 2'b01; #1;
    checks++;
    if (br_tk !== 1'b0) begin
      failures++; $display("FAIL bne_equal got=%b exp=0", br_tk);
    end
    brn_signal = 2'b00; #1;
    checks++;
    if (br_tk !== 1'b1) begin
      failures++; $display("FAIL beq_equal got=%b exp=1", br_tk);
    end
  endtask

  task automatic test_enable();
    cmp_a = 32'h5; cmp_b = 32'h5; brn_enable = 1'b0;
    for (int s = 0; s < 4; s++) begin
      brn_signal = 2'(s); #1;
      checks++;
      if (br_tk !== 1'b0) begin
        failures++; $display("FAIL enable_gate_sig%0d got=%b exp=0", s, br_tk);
      end
    end
  endtask

  task automatic test_register();
    @(negedge clock);
    in_a = 32'h55; in_b = 32'h0; alu_sel = 4'd0;
    cmp_a = 32'h9; cmp_b = 32'h9; brn_enable = 1'b1; brn_signal = 2'b00;
    advance = 1'b1;
    @(posedge clock); #1;
    checks++;
    if (alu_out_q !== 32'h55) begin
      failures++; $display("FAIL load_alu_q got=%h exp=%h", alu_out_q, 32'h55);
    end
    @(negedge clock);
    advance = 1'b0; in_a = 32'h99; brn_signal = 2'b01;
    @(posedge clock); #1;
    checks++;
    if (alu_out_q !== 32'h55) begin
      failures++; $display("FAIL hold_alu_q got=%h exp=%h", alu_out_q, 32'h55);
    end
    checks++;
    if (br_tk_q !== 1'b1) begin
      failures++; $display("FAIL hold_br_tk_q got=%b exp=1", br_tk_q);
    end
    @(negedge clock);
    #1 reset = 1'b1;
    #1;
    checks++;
    if (alu_out_q !== 32'h0) begin
      failures++; $display("FAIL async_reset_alu_q got=%h exp=%h", alu_out_q, 32'h0);
    end
    checks++;
    if (br_tk_q !== 1'b0) begin
      failures++; $display("FAIL async_reset_br_tk_q got=%b exp=0", br_tk_q);
    end
    reset = 1'b0; advance = 1'b1; in_a = 32'h77; brn_signal = 2'b00; #1;
    checks++;
    if (alu_out_q !== 32'h0) begin
      failures++; $display("FAIL post_release_no_edge got=%h exp=%h", alu_out_q, 32'h0);
    end
    @(posedge clock); #1;
    advance = 1'b0;
    checks++;
    if (alu_out_q !== 32'h77) begin
      failures++; $display("FAIL reload_alu_q got=%h exp=%h", alu_out_q, 32'h77);
    end
    checks++;
    if (br_tk_q !== 1'b1) begin
      failures++; $display("FAIL reload_br_tk_q got=%b exp=1", br_tk_q);
    end
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_shifts();
    test_slt();
    test_branch();
    test_enable();
    test_register();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
